// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN (adds err port).
module spi_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int data_width     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*data_width-1:0]   tx_data,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              grant,
    output logic [data_width-1:0]           rx_data,
    output logic                            busy,
    output logic [NUM_REQ-1:0]              slave_cs_n,
    output logic                            spi_enable,
    output logic [data_width-1:0]           spi_data_in,
    input  logic                            spi_cs,
    input  logic [data_width-1:0]           spi_data_out,
    output logic                            spi_abort
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    output logic                            err
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         gidx_q, gidx_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [data_width-1:0] rx_data_q, rx_data_d;
    logic [data_width-1:0] tx_q, tx_d;
    logic                  spi_cs_q;
    logic [data_width-1:0] rx_shadow_q;

    logic                  sel_hit;
    logic [PW-1:0]         sel_idx;
    int                    cand;
    logic                  cs_rise;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          abort;
`endif

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!sel_hit && req[cand]) begin
                sel_hit = 1'b1;
                sel_idx = cand[PW-1:0];
            end
        end
    end

    // Master data_out is only valid in its last cs-low cycle, so use the shadow.
    assign cs_rise = !spi_cs_q && spi_cs;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        rx_data_d = rx_data_q;
        tx_d      = tx_q;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
        abort     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_hit) begin
                    gidx_d          = sel_idx;
                    grant_d         = '0;
                    grant_d[sel_idx] = 1'b1;
                    tx_d            = tx_data[sel_idx*data_width +: data_width];
                    state_d         = S_START;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d           = 1'b0;
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (cs_rise) begin
                    rx_data_d = rx_shadow_q;
                    state_d   = S_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    abort     = 1'b1;
                    rx_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                rr_ptr_d = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                grant_d  = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            rx_data_q   <= '0;
            tx_q        <= '0;
            spi_cs_q    <= 1'b1;
            rx_shadow_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            rx_data_q   <= rx_data_d;
            tx_q        <= tx_d;
            spi_cs_q    <= spi_cs;
            rx_shadow_q <= spi_data_out;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign spi_enable  = (state_q == S_START);
    assign done        = (state_q == S_DONE) ? grant_q : '0;
    assign grant       = grant_q;
    assign rx_data     = rx_data_q;
    assign spi_data_in = tx_q;
    assign slave_cs_n  = (state_q == S_START || state_q == S_WAIT)
                         ? ~(grant_q & {NUM_REQ{~spi_cs}}) : '1;

`ifdef SPI_ARB_TIMEOUT_EN
    assign spi_abort = abort;
    assign err       = err_q;
`else
    assign spi_abort = 1'b0;
`endif

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Scoreboard bench for spi_request_arbiter with a behavioural SPI master driven from tasks.
module tb_spi_request_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   tx_data;
    logic [N-1:0]     done, grant, slave_cs_n;
    logic [W-1:0]     rx_data, spi_data_in;
    logic             busy, spi_enable, spi_abort;
    logic             spi_cs = 1'b1;
    logic [W-1:0]     spi_data_out = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    logic             err;
`endif

    spi_request_arbiter #(.NUM_REQ(N), .data_width(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data),
        .done(done), .grant(grant), .rx_data(rx_data), .busy(busy),
        .slave_cs_n(slave_cs_n), .spi_enable(spi_enable), .spi_data_in(spi_data_in),
        .spi_cs(spi_cs), .spi_data_out(spi_data_out), .spi_abort(spi_abort)
`ifdef SPI_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] rx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done !== '0) begin
            if (sb.size() == 0) begin
                chk("done_spurious", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_vec", 32'(done), 32'(e.g));
                chk("rx_data", 32'(rx_data), 32'(e.rx));
            end
            done_cnt++;
        end
    end

    task automatic wait_enable(output bit ok);
        int t;
        t = 0;
        while (spi_enable !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (spi_enable === 1'b1);
        if (!ok) chk("enable_timeout", 32'(spi_enable), 32'h1);
    endtask

    // One transfer: expect grant gi, master returns rxw after len cs-low cycles.
    task automatic xfer(input int gi, input logic [W-1:0] rxw, input int len,
                        input int drop_cyc, input logic [N-1:0] drop_mask,
                        input logic [N-1:0] req_after);
        logic [N-1:0] g, gn;
        logic [W-1:0] txe;
        bit ok;
        int t, dc0;
        g = '0;
        g[gi] = 1'b1;
        gn = ~g;
        txe = tx_data[gi*W +: W];
        wait_enable(ok);
        if (!ok) return;
        chk("grant", 32'(grant), 32'(g));
        chk("spi_data_in", 32'(spi_data_in), 32'(txe));
        chk("busy", 32'(busy), 32'h1);
        sb.push_back('{g: g, rx: rxw});
        dc0 = done_cnt;
        @(posedge clk); #1;
        spi_cs = 1'b0;
        tx_data = ~tx_data;
        for (int i = 0; i < len; i++) begin
            spi_data_out = (i == len - 1) ? rxw : W'($urandom);
            if (i == drop_cyc) req = req & ~drop_mask;
            @(negedge clk);
            if (i == 0) chk("enable_one_cycle", 32'(spi_enable), 32'h0);
            chk("slave_cs_n", 32'(slave_cs_n), 32'(gn));
            chk("spi_data_in_hold", 32'(spi_data_in), 32'(txe));
            @(posedge clk); #1;
        end
        tx_data = ~tx_data;
        spi_cs = 1'b1;
        spi_data_out = '0;
        t = 0;
        while (done_cnt == dc0 && t < 10) begin
            @(negedge clk); #1;
            t++;
        end
        if (done_cnt == dc0) chk("done_timeout", 32'(done_cnt), 32'(dc0 + 1));
        req = req_after;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
    endtask

    initial begin
        bit ok;
        int dc;
        tx_data = {8'hD4, 8'hC3, 8'hA5, 8'hB1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rx", 32'(rx_data), 32'h0);
        chk("rst_din", 32'(spi_data_in), 32'h0);
        chk("rst_en", 32'(spi_enable), 32'h0);
        chk("rst_cs_n", 32'(slave_cs_n), 32'hF);
        chk("rst_abort", 32'(spi_abort), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // All requesters held: 0,1,2,3,0
        req = 4'b1111;
        xfer(0, 8'h11, 3, -1, '0, 4'b1111);
        xfer(1, 8'h22, 4, -1, '0, 4'b1111);
        xfer(2, 8'h33, 2, -1, '0, 4'b1111);
        xfer(3, 8'h44, 5, -1, '0, 4'b1111);
        xfer(0, 8'h55, 3, -1, '0, 4'b0000);

        // Single request from requester 1; rr_ptr then points at 2
        req = 4'b0010;
        xfer(1, 8'h3C, 8, -1, '0, 4'b0000);
        req = 4'b1111;
        xfer(2, 8'h5A, 2, -1, '0, 4'b0000);

        // Wrap: rr_ptr=3 with req 1001 grants 3 then 0
        req = 4'b1001;
        xfer(3, 8'h77, 3, -1, '0, 4'b1001);
        xfer(0, 8'h99, 3, -1, '0, 4'b0000);

        // Requester 2 drops req mid-transfer
        req = 4'b0100;
        xfer(2, 8'hE7, 8, 3, 4'b0100, 4'b0000);

        // Reset while in WAIT: no done, outputs at reset values
        req = 4'b0001;
        wait_enable(ok);
        dc = done_cnt;
        @(posedge clk); #1;
        spi_cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        req = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_rx", 32'(rx_data), 32'h0);
        chk("mid_rst_din", 32'(spi_data_in), 32'h0);
        chk("mid_rst_cs_n", 32'(slave_cs_n), 32'hF);
        chk("mid_rst_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));

        // rr_ptr back at 0 after reset
        req = 4'b1111;
        xfer(0, 8'h6B, 3, -1, '0, 4'b0000);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            int t;
            req = 4'b0010;
            wait_enable(ok);
            sb.push_back('{g: 4'b0010, rx: 8'h00});
            @(posedge clk); #1;
            spi_cs = 1'b0;
            t = 0;
            while (spi_abort !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("abort_cycle", 32'(t), 32'd16);
            req = '0;
            @(negedge clk);
            chk("abort_one_cycle", 32'(spi_abort), 32'h0);
            chk("err", 32'(err), 32'h1);
            chk("rx_after_abort", 32'(rx_data), 32'h0);
            @(posedge clk); #1;
            spi_cs = 1'b1;
            repeat (3) @(negedge clk);
        end
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
